// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_pkg
// Purpose : Default 640x480@60 VGA timing, position type, FSM state type,
//           strVGA stream field bounds and small decode helpers shared by
//           the VGA sync generator and its neighbours.
// Revision: 1.0  initial release
// ============================================================================
package vga_timing_pkg;

  // Default 640x480@60 timing (25 MHz pixel clock).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Positions are 10 bits wide, so a line or frame may hold at most 1024 steps.
  localparam int POS_W     = 10;
  localparam int POS_RANGE = 1 << POS_W;

  // strVGA stream layout used by the downstream zipper.
  localparam int STRVGA_W = 23;
  localparam int XC_MSB   = 22;
  localparam int XC_LSB   = 13;
  localparam int YC_MSB   = 12;
  localparam int YC_LSB   = 3;
  localparam int HS_BIT   = 2;
  localparam int VS_BIT   = 1;
  localparam int ACT_BIT  = 0;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // True when lo <= p < hi.
  function automatic logic in_range(input pos_t p, input int lo, input int hi);
    return (int'(p) >= lo) && (int'(p) < hi);
  endfunction

  // Packs one pixel's timing fields into the strVGA word.
  function automatic logic [STRVGA_W-1:0] pack_strvga(
    input pos_t x,
    input pos_t y,
    input logic hs,
    input logic vs,
    input logic act
  );
    logic [STRVGA_W-1:0] w;
    w                 = '0;
    w[XC_MSB:XC_LSB]  = x;
    w[YC_MSB:YC_LSB]  = y;
    w[HS_BIT]         = hs;
    w[VS_BIT]         = vs;
    w[ACT_BIT]        = act;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : vga_sync_gen_if
// Purpose : Video timing bundle between the sync generator (master) and its
//           consumers (slave). The enable travels against the data flow.
// Revision: 1.0  initial release
// ============================================================================
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic       en;
  logic       hsync;
  logic       vsync;
  pos_t       x_px;
  pos_t       y_px;
  logic       activevideo;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    input  en,
    output hsync,
    output vsync,
    output x_px,
    output y_px,
    output activevideo,
    output line_start,
    output frame_start,
    output frame_cnt
  );

  modport slave (
    output en,
    input  hsync,
    input  vsync,
    input  x_px,
    input  y_px,
    input  activevideo,
    input  line_start,
    input  frame_start,
    input  frame_cnt
  );

endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module  : vga_axis_counter
// Purpose : 10-bit modular position counter for one screen axis. Exposes the
//           registered count, the value it will take on the next edge, and a
//           wrap flag that is high when this increment rolls TOTAL-1 to 0.
// Revision: 1.0  initial release
// ============================================================================
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  output pos_t count,
  output pos_t nxt,
  output logic wrap
);

  localparam pos_t LAST = pos_t'(TOTAL - 1);

  // Next value and wrap flag; the top decodes its flags from nxt so that
  // they land in the same cycle as the count they describe.
  always_comb begin
    nxt  = count;
    wrap = 1'b0;
    if (inc) begin
      if (count == LAST) begin
        nxt  = '0;
        wrap = 1'b1;
      end else begin
        nxt = count + pos_t'(1);
      end
    end
  end

  // Position register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_sync_gen
// Purpose : Pixel-clock VGA timing generator. Produces registered, mutually
//           aligned hsync/vsync/position/activevideo plus line and frame
//           start strobes and a completed-frame counter.
// Revision: 1.0  initial release
// ============================================================================
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic           px_clk,
  input  logic           rst_n,
  vga_sync_gen_if.master vid
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  state_t     state;
  state_t     state_nxt;
  logic       run;

  logic       h_inc;
  logic       h_wrap;
  logic       v_wrap;
  pos_t       h_count;
  pos_t       h_nxt;
  pos_t       v_count;
  pos_t       v_nxt;

  logic       dec_hsync;
  logic       dec_vsync;
  logic       dec_active;
  logic       dec_line;
  logic       dec_frame;

  logic       hsync_q;
  logic       vsync_q;
  logic       active_q;
  logic       line_q;
  logic       frame_q;
  logic [7:0] frame_cnt_q;

  // State register.
  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave IDLE on the first enabled edge and stay in RUN.
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vid.en) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        run = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // The first enabled edge only starts the generator, so position stays at
  // (0,0) while the flags for (0,0) are loaded.
  assign h_inc = vid.en & run;

  vga_axis_counter #(
    .TOTAL (H_TOTAL)
  ) u_h_cnt (
    .clk   (px_clk),
    .rst_n (rst_n),
    .inc   (h_inc),
    .count (h_count),
    .nxt   (h_nxt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL)
  ) u_v_cnt (
    .clk   (px_clk),
    .rst_n (rst_n),
    .inc   (h_wrap),
    .count (v_count),
    .nxt   (v_nxt),
    .wrap  (v_wrap)
  );

  // Decode the flags from the position the counters move to on this edge.
  always_comb begin
    dec_hsync  = in_range(h_nxt, HS_START, HS_END) ? HS_POL : ~HS_POL;
    dec_vsync  = in_range(v_nxt, VS_START, VS_END) ? VS_POL : ~VS_POL;
    dec_active = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
    dec_line   = (h_nxt == '0);
    dec_frame  = (h_nxt == '0) && (v_nxt == '0);
  end

  // Output flag registers and frame counter; strobes drop while frozen.
  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      active_q    <= 1'b0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else if (vid.en) begin
      hsync_q  <= dec_hsync;
      vsync_q  <= dec_vsync;
      active_q <= dec_active;
      line_q   <= dec_line;
      frame_q  <= dec_frame;
      if (v_wrap) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end else begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end
  end

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.x_px        = h_count;
  assign vid.y_px        = v_count;
  assign vid.activevideo = active_q;
  assign vid.line_start  = line_q;
  assign vid.frame_start = frame_q;
  assign vid.frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_sync_gen
// Purpose : Self-checking bench for vga_sync_gen. Three instances share the
//           enable and reset: default 640x480 timing, and a tiny 16x12 timing
//           with active-low and with active-high sync pulses.
// Revision: 1.0  initial release
// ============================================================================
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  typedef struct {
    logic run;
    int   x;
    int   y;
    int   fc;
    logic hs;
    logic vs;
    logic av;
    logic ls;
    logic fs;
  } mstate_t;

  typedef struct {
    int   ha, hf, hsy, hb;
    int   va, vf, vsy, vb;
    logic hp, vp;
  } cfg_t;

  logic    px_clk = 1'b0;
  logic    rst_n;
  logic    en_drv;
  int      n_vec = 0;
  int      n_bad = 0;
  cfg_t    cfg[3];
  mstate_t ms[3];
  mstate_t sb_q[3][$];

  always #5 px_clk = ~px_clk;

  vga_sync_gen_if if_a ();
  vga_sync_gen_if if_b ();
  vga_sync_gen_if if_c ();

  assign if_a.en = en_drv;
  assign if_b.en = en_drv;
  assign if_c.en = en_drv;

  vga_sync_gen dut_a (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .vid    (if_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_b (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .vid    (if_b)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_c (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .vid    (if_c)
  );

  // Behavioural reference: what every output should read after one edge.
  function automatic mstate_t model_step(input mstate_t s, input cfg_t c,
                                         input logic rn, input logic e);
    mstate_t n;
    int ht;
    int vt;
    n  = s;
    ht = c.ha + c.hf + c.hsy + c.hb;
    vt = c.va + c.vf + c.vsy + c.vb;
    if (!rn) begin
      n.run = 1'b0; n.x = 0; n.y = 0; n.fc = 0;
      n.av = 1'b0; n.ls = 1'b0; n.fs = 1'b0;
      n.hs = ~c.hp; n.vs = ~c.vp;
      return n;
    end
    if (!e) begin
      n.ls = 1'b0;
      n.fs = 1'b0;
      return n;
    end
    if (s.run) begin
      if (s.x == ht - 1) begin
        n.x = 0;
        if (s.y == vt - 1) begin
          n.y  = 0;
          n.fc = (s.fc + 1) % 256;
        end else begin
          n.y = s.y + 1;
        end
      end else begin
        n.x = s.x + 1;
      end
    end
    n.run = 1'b1;
    n.av  = (n.x < c.ha) && (n.y < c.va);
    n.ls  = (n.x == 0);
    n.fs  = (n.x == 0) && (n.y == 0);
    n.hs  = (n.x >= c.ha + c.hf && n.x < c.ha + c.hf + c.hsy) ? c.hp : ~c.hp;
    n.vs  = (n.y >= c.va + c.vf && n.y < c.va + c.vf + c.vsy) ? c.vp : ~c.vp;
    return n;
  endfunction

  function automatic mstate_t grab(input logic [9:0] x, input logic [9:0] y,
                                   input logic [7:0] fc, input logic hs,
                                   input logic vs, input logic av,
                                   input logic ls, input logic fs);
    mstate_t a;
    a.run = 1'b0;
    a.x = int'(x); a.y = int'(y); a.fc = int'(fc);
    a.hs = hs; a.vs = vs; a.av = av; a.ls = ls; a.fs = fs;
    return a;
  endfunction

  task automatic compare(input int idx, input mstate_t e, input mstate_t a);
    n_vec++;
    if (a.x != e.x || a.y != e.y || a.fc != e.fc || a.hs !== e.hs ||
        a.vs !== e.vs || a.av !== e.av || a.ls !== e.ls || a.fs !== e.fs) begin
      n_bad++;
      $display("FAIL scoreboard dut%0d t=%0t: got x=%0d y=%0d fc=%0d hs=%b vs=%b av=%b ls=%b fs=%b, want x=%0d y=%0d fc=%0d hs=%b vs=%b av=%b ls=%b fs=%b",
               idx, $time, a.x, a.y, a.fc, a.hs, a.vs, a.av, a.ls, a.fs,
               e.x, e.y, e.fc, e.hs, e.vs, e.av, e.ls, e.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Apply one vector, push the expected result, let the edge happen.
  task automatic cycle(input logic rn, input logic e);
    rst_n  = rn;
    en_drv = e;
    for (int i = 0; i < 3; i++) begin
      ms[i] = model_step(ms[i], cfg[i], rn, e);
      sb_q[i].push_back(ms[i]);
    end
    @(negedge px_clk);
  endtask

  // Monitor: after every rising edge, pop and compare each instance.
  initial begin : monitor
    mstate_t e;
    mstate_t a;
    forever begin
      @(posedge px_clk);
      #1;
      if (sb_q[0].size() > 0) begin
        e = sb_q[0].pop_front();
        a = grab(if_a.x_px, if_a.y_px, if_a.frame_cnt, if_a.hsync, if_a.vsync,
                 if_a.activevideo, if_a.line_start, if_a.frame_start);
        compare(0, e, a);
      end
      if (sb_q[1].size() > 0) begin
        e = sb_q[1].pop_front();
        a = grab(if_b.x_px, if_b.y_px, if_b.frame_cnt, if_b.hsync, if_b.vsync,
                 if_b.activevideo, if_b.line_start, if_b.frame_start);
        compare(1, e, a);
      end
      if (sb_q[2].size() > 0) begin
        e = sb_q[2].pop_front();
        a = grab(if_c.x_px, if_c.y_px, if_c.frame_cnt, if_c.hsync, if_c.vsync,
                 if_c.activevideo, if_c.line_start, if_c.frame_start);
        compare(2, e, a);
      end
    end
  end

  initial begin : stimulus
    int cnt_hs, cnt_av, cnt_ls, cnt_fs;
    int cnt_vb, cnt_vc, cnt_hb, cnt_hc;
    int fs_first, fs_second, pos_before, strobe_off, found;
    int prev_b, prev_c, wraps_b, wraps_c;

    cfg[0] = '{ha:640, hf:16, hsy:96, hb:48, va:480, vf:10, vsy:2, vb:33, hp:1'b0, vp:1'b0};
    cfg[1] = '{ha:8, hf:2, hsy:3, hb:3, va:6, vf:1, vsy:2, vb:3, hp:1'b0, vp:1'b0};
    cfg[2] = '{ha:8, hf:2, hsy:3, hb:3, va:6, vf:1, vsy:2, vb:3, hp:1'b1, vp:1'b1};
    for (int i = 0; i < 3; i++) begin
      ms[i] = '{run:1'b0, x:0, y:0, fc:0, hs:1'b1, vs:1'b1, av:1'b0, ls:1'b0, fs:1'b0};
    end

    // 1. Reset held five cycles, then enable.
    repeat (5) cycle(1'b0, 1'b0);
    check_int("rst_x", int'(if_a.x_px), 0);
    check_int("rst_hsync", int'(if_a.hsync), 1);
    check_int("rst_active", int'(if_a.activevideo), 0);
    check_int("rst_hsync_pol1", int'(if_c.hsync), 0);
    cycle(1'b1, 1'b1);
    check_int("start_fs", int'(if_a.frame_start), 1);
    check_int("start_av", int'(if_a.activevideo), 1);
    check_int("start_x", int'(if_a.x_px), 0);

    // 2. One full 800-pixel line on the default-timing instance.
    cnt_hs = 0; cnt_av = 0; cnt_ls = 0; cnt_fs = 0;
    for (int k = 0; k < 800; k++) begin
      cycle(1'b1, 1'b1);
      if (!if_a.hsync) cnt_hs++;
      if (if_a.activevideo) cnt_av++;
      if (if_a.line_start) cnt_ls++;
      if (if_a.frame_start) cnt_fs++;
    end
    check_int("line_hsync_low", cnt_hs, 96);
    check_int("line_active", cnt_av, 640);
    check_int("line_starts", cnt_ls, 1);
    check_int("line_frame_starts", cnt_fs, 0);
    check_int("line_end_x", int'(if_a.x_px), 0);
    check_int("line_end_y", int'(if_a.y_px), 1);

    // 3. Two whole small frames: sync pulse counts and frame period.
    cnt_vb = 0; cnt_vc = 0; cnt_hb = 0; cnt_hc = 0;
    fs_first = -1; fs_second = -1;
    for (int k = 0; k < 384; k++) begin
      cycle(1'b1, 1'b1);
      if (!if_b.vsync) cnt_vb++;
      if (if_c.vsync) cnt_vc++;
      if (!if_b.hsync) cnt_hb++;
      if (if_c.hsync) cnt_hc++;
      if (if_b.frame_start) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
    end
    check_int("frame_vsync_low_b", cnt_vb, 64);
    check_int("frame_vsync_high_c", cnt_vc, 64);
    check_int("frame_hsync_low_b", cnt_hb, 72);
    check_int("frame_hsync_high_c", cnt_hc, 72);
    check_int("frame_start_period", fs_second - fs_first, 192);

    // 4. Enable toggling every cycle for 1000 cycles.
    pos_before = int'(if_a.y_px) * 800 + int'(if_a.x_px);
    strobe_off = 0;
    for (int k = 0; k < 1000; k++) begin
      cycle(1'b1, (k % 2) == 0);
      if ((k % 2) != 0) begin
        strobe_off += int'(if_a.line_start) + int'(if_a.frame_start) +
                      int'(if_b.line_start) + int'(if_b.frame_start) +
                      int'(if_c.line_start) + int'(if_c.frame_start);
      end
    end
    check_int("toggle_advance", int'(if_a.y_px) * 800 + int'(if_a.x_px) - pos_before, 500);
    check_int("toggle_strobes_when_frozen", strobe_off, 0);

    // 5. Reset mid-frame while the small instance is inside its hsync pulse.
    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      cycle(1'b1, 1'b1);
      if (if_b.x_px == 10'd10 && if_b.y_px == 10'd5) found = 1;
    end
    check_int("seek_sync_point", found, 1);
    check_int("pre_reset_hsync_b", int'(if_b.hsync), 0);
    cycle(1'b0, 1'b1);
    check_int("mid_reset_x", int'(if_b.x_px), 0);
    check_int("mid_reset_y", int'(if_b.y_px), 0);
    check_int("mid_reset_hsync", int'(if_b.hsync), 1);
    check_int("mid_reset_active", int'(if_b.activevideo), 0);
    check_int("mid_reset_fc", int'(if_b.frame_cnt), 0);

    // 6. 256 small frames: the frame counter wraps 255 -> 0 exactly once.
    cycle(1'b1, 1'b1);
    prev_b = int'(if_b.frame_cnt); prev_c = int'(if_c.frame_cnt);
    wraps_b = 0; wraps_c = 0;
    for (int k = 0; k < 256 * 192 + 10; k++) begin
      cycle(1'b1, 1'b1);
      if (prev_b == 255 && if_b.frame_cnt == 8'd0) wraps_b++;
      if (prev_c == 255 && if_c.frame_cnt == 8'd0) wraps_c++;
      prev_b = int'(if_b.frame_cnt);
      prev_c = int'(if_c.frame_cnt);
    end
    check_int("fc_wraps_b", wraps_b, 1);
    check_int("fc_wraps_c", wraps_c, 1);
    check_int("fc_final_b", int'(if_b.frame_cnt), 0);

    // Drain the scoreboard within a bounded number of edges.
    for (int k = 0; k < 4 && (sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) > 0; k++) begin
      @(posedge px_clk);
      #2;
    end
    check_int("scoreboard_drained", sb_q[0].size() + sb_q[1].size() + sb_q[2].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
